ordena8_collector: RTL and testbench
====================================

// Module: ordena8_collector
// PURPOSE
//  Upstream stage of the 8-input sorter. Accepts a byte stream over a valid/ready handshake.
//  Assembles 8 consecutive bytes into a frame and presents them on input_1..input_8, with frame_valid/frame_ready.
//  Frame order: first accepted byte -> input_1, eighth -> input_8. The sorter consumes the frame when frame_ready is high.
// PARAMETERS
//  DATA_W     8      width of each stream byte / frame slot
//  N_SLOTS    8      bytes per frame; fixed at 8 to match the sorter, elaborated with an assertion
//  PAD_VALUE  8'hFF  fill value for unused slots on flush (used only with FRAME_FLUSH_EN)
// PORTS
//  clk          in   1       single clock, all logic on rising edge
//  rst          in   1       synchronous, active-high reset
//  in_data      in   DATA_W  stream byte
//  in_valid     in   1       in_data valid
//  in_ready     out  1       collector can accept a byte
//  flush        in   1       close partial frame (present only with FRAME_FLUSH_EN)
//  input_1..8   out  DATA_W  frame slots to sorter, registered
//  frame_valid  out  1       frame in input_1..8 is complete and stable
//  frame_ready  in   1       sorter takes the frame
//  fill_count   out  4       bytes captured in current frame, 0..8
//  frame_cnt    out  16      frames handed off since reset, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset (rst=1 at edge): state=FILL, fill_count=0, input_1..8=0, frame_valid=0, frame_cnt=0; in_ready=1 the cycle after reset.
//  The partial or held frame is discarded on reset. Reset has priority over all other inputs.
//  FSM states: FILL, HOLD.
//   FILL: in_ready=1, frame_valid=0. On in_valid&in_ready, write in_data to slot[fill_count+1] and increment fill_count.
//     The accept of the 8th byte moves the FSM to HOLD. Slots are visible on their outputs one cycle after acceptance.
//   HOLD: in_ready=0, frame_valid=1, fill_count=8, slots frozen.
//     On frame_valid&frame_ready: next state FILL, fill_count=0, frame_cnt+1.
//     Slot values are retained until overwritten.
//  Latency: frame_valid rises the cycle after the 8th accept. The earliest handoff is therefore that same cycle.
//  No bypass: in the handoff cycle in_ready=0, so the first byte of the next frame is accepted one cycle after handoff at the earliest.
//  Throughput: at most 8 bytes per 9 cycles when frame_ready is held high.
//  frame_ready while frame_valid=0 has no effect. in_valid while in_ready=0 has no effect; the byte is not consumed.
//  in_ready and frame_valid are decoded from registered state only, with no combinational path from frame_ready or in_valid.
// CONFIGURATION
//  FRAME_FLUSH_EN defined: flush port exists.
//   flush=1 in FILL with fill_count>0 closes the frame: remaining slots are written PAD_VALUE, then HOLD next cycle.
//   If a byte is accepted in the same cycle, that byte takes its slot first and the padding follows it.
//   If that byte is the 8th, the frame closes normally.
//   flush with fill_count=0 and no accept is ignored; flush in HOLD is ignored.
//  FRAME_FLUSH_EN undefined: no flush port, and frames close only on the 8th byte.
// STRUCTURE
//  ordena8_pkg: DATA_W, N_SLOTS, PAD_VALUE default, typedef byte_t, typedef frame_t (byte_t [N_SLOTS]),
//   and typedef enum logic {FILL, HOLD} coll_state_t.
//  No sub-module: slot register array, FSM and counters are inline. Outputs input_1..8 map to frame_t elements 0..7.
// TESTING
//  Reset then stream 8'h10,20,..,80 back-to-back with frame_ready=1
//   -> input_1..8 = 10..80, frame_valid high 1 cycle, frame_cnt=1.
//  Fill 8 bytes with frame_ready=0 for 5 cycles -> frame_valid holds, in_ready=0, slots stable.
//   A 9th byte 8'hAA is offered meanwhile and not accepted.
//   After frame_ready=1, 8'hAA is accepted as input_1 of the next frame.
//  in_valid toggled 1/0 for bytes 3,1,4,1,5,9,2,6 -> fill_count steps only on accepts, and the frame equals that order.
//  rst=1 after 5 accepted bytes -> fill_count=0, outputs 0, frame_valid=0.
//   The next 8 bytes form a clean frame and frame_cnt=1.
//  FRAME_FLUSH_EN: 3 bytes 8'h05,07,09, then flush -> frame 05,07,09,FF,FF,FF,FF,FF.
//   flush at fill_count=0 produces no frame.
//  frame_cnt preloaded via force to 16'hFFFF, then one handoff -> frame_cnt=0.

Source files
------------

// File: rtl/ordena8_pkg.sv
// Shared types for the 8-input sorter front end: slot width, frame shape and collector FSM states.
// Optional flush support is selected with FRAME_FLUSH_EN.
package ordena8_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned N_SLOTS = 8;
  localparam logic [DATA_W-1:0] PAD_VALUE_DEF = 8'hFF;

  typedef logic [DATA_W-1:0] byte_t;
  typedef byte_t frame_t [N_SLOTS];

  typedef enum logic {FILL, HOLD} coll_state_t;

endpackage

// File: rtl/ordena8_collector_if.sv
// Stream-in / frame-out bundle of ordena8_collector; slave is the collector, master the surrounding logic.
// The flush wire exists only when FRAME_FLUSH_EN is defined.
interface ordena8_collector_if;
  import ordena8_pkg::*;

  byte_t       in_data;
  logic        in_valid;
  logic        in_ready;
`ifdef FRAME_FLUSH_EN
  logic        flush;
`endif
  byte_t       input_1;
  byte_t       input_2;
  byte_t       input_3;
  byte_t       input_4;
  byte_t       input_5;
  byte_t       input_6;
  byte_t       input_7;
  byte_t       input_8;
  logic        frame_valid;
  logic        frame_ready;
  logic [3:0]  fill_count;
  logic [15:0] frame_cnt;

  modport slave (
`ifdef FRAME_FLUSH_EN
    input  flush,
`endif
    input  in_data, in_valid, frame_ready,
    output in_ready, frame_valid, fill_count, frame_cnt,
    output input_1, input_2, input_3, input_4, input_5, input_6, input_7, input_8
  );

  modport master (
`ifdef FRAME_FLUSH_EN
    output flush,
`endif
    output in_data, in_valid, frame_ready,
    input  in_ready, frame_valid, fill_count, frame_cnt,
    input  input_1, input_2, input_3, input_4, input_5, input_6, input_7, input_8
  );

endinterface

// File: rtl/ordena8_collector.sv
// Packs 8 accepted stream bytes into a registered frame for the sorter; holds it until frame_ready, one idle cycle per handoff.
// FRAME_FLUSH_EN adds a flush input that pads and closes a partial frame.
module ordena8_collector #(
  parameter int unsigned             DATA_W    = ordena8_pkg::DATA_W,
  parameter int unsigned             N_SLOTS   = ordena8_pkg::N_SLOTS,
  parameter logic [DATA_W-1:0]       PAD_VALUE = ordena8_pkg::PAD_VALUE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  ordena8_collector_if.slave   bus
);
  import ordena8_pkg::*;

  if (N_SLOTS != 8) begin : g_bad_slots
    $error("ordena8_collector: N_SLOTS must be 8");
  end
  if (DATA_W != $bits(byte_t) || $bits(PAD_VALUE) != DATA_W) begin : g_bad_width
    $error("ordena8_collector: DATA_W must match the package byte width");
  end

  coll_state_t state_q, state_d;
  logic [3:0]  fill_q, fill_d;
  frame_t      slot_q, slot_d;
  logic [15:0] frame_cnt_q;
  logic        accept;
  logic        handoff;

  // Handshake outputs depend only on the registered state.
  assign bus.in_ready    = (state_q == FILL);
  assign bus.frame_valid = (state_q == HOLD);
  assign accept          = bus.in_valid && (state_q == FILL);
  assign handoff         = bus.frame_ready && (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    slot_d  = slot_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          slot_d[fill_q[2:0]] = bus.in_data;
          fill_d              = fill_q + 4'd1;
        end
        if (fill_d == 4'(N_SLOTS)) begin
          state_d = HOLD;
        end
`ifdef FRAME_FLUSH_EN
        // A byte accepted alongside flush keeps its slot; padding starts after it.
        else if (bus.flush && fill_d != 4'd0) begin
          for (int i = 0; i < int'(N_SLOTS); i++) begin
            if (4'(i) >= fill_d) begin
              slot_d[i] = PAD_VALUE;
            end
          end
          fill_d  = 4'(N_SLOTS);
          state_d = HOLD;
        end
`endif
      end
      HOLD: begin
        if (bus.frame_ready) begin
          state_d = FILL;
          fill_d  = 4'd0;
        end
      end
      default: begin
        state_d = FILL;
        fill_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      fill_q      <= 4'd0;
      slot_q      <= '{default: '0};
      frame_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      slot_q  <= slot_d;
      if (handoff) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign bus.fill_count = fill_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.input_1    = slot_q[0];
  assign bus.input_2    = slot_q[1];
  assign bus.input_3    = slot_q[2];
  assign bus.input_4    = slot_q[3];
  assign bus.input_5    = slot_q[4];
  assign bus.input_6    = slot_q[5];
  assign bus.input_7    = slot_q[6];
  assign bus.input_8    = slot_q[7];

endmodule

// File: tb/tb_ordena8_collector.sv
// Bench for ordena8_collector: directed tables and sequences plus random traffic against a frame-level model.
// Build with FRAME_FLUSH_EN to cover the flush feature.
module tb_ordena8_collector;
  import ordena8_pkg::*;

`ifdef FRAME_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ordena8_collector_if bus ();

  ordena8_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          vld;
    logic [7:0]  dat;
    bit          frdy;
    bit          flsh;
    logic [3:0]  e_fill;
    bit          e_rdy;
    bit          e_fv;
    logic [15:0] e_cnt;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level reference: bytes of the open frame, whether a frame is waiting, visible slots.
  logic [7:0]  m_q[$];
  bit          m_held;
  logic [7:0]  m_slot [8];
  logic [15:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] slot_of(input int i);
    case (i)
      0: return bus.input_1;
      1: return bus.input_2;
      2: return bus.input_3;
      3: return bus.input_4;
      4: return bus.input_5;
      5: return bus.input_6;
      6: return bus.input_7;
      default: return bus.input_8;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_held = 1'b0;
    m_cnt  = 16'd0;
    for (int i = 0; i < 8; i++) m_slot[i] = 8'h00;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit fr, input bit fl);
    if (m_held) begin
      if (fr) begin
        m_held = 1'b0;
        m_q.delete();
        m_cnt = m_cnt + 16'd1;
      end
    end else begin
      if (v) begin
        m_slot[m_q.size()] = d;
        m_q.push_back(d);
      end
      if (m_q.size() == 8) begin
        m_held = 1'b1;
      end else if (FLUSH_ON && fl && m_q.size() > 0) begin
        while (m_q.size() < 8) begin
          m_slot[m_q.size()] = 8'hFF;
          m_q.push_back(8'hFF);
        end
        m_held = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    chk("model_in_ready", 32'(bus.in_ready), 32'(!m_held));
    chk("model_frame_valid", 32'(bus.frame_valid), 32'(m_held));
    chk("model_fill_count", 32'(bus.fill_count), 32'(m_q.size()));
    chk("model_frame_cnt", 32'(bus.frame_cnt), 32'(m_cnt));
    for (int i = 0; i < 8; i++) chk($sformatf("model_slot%0d", i + 1), 32'(slot_of(i)), 32'(m_slot[i]));
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input bit fr, input bit fl);
    bus.in_valid    = v;
    bus.in_data     = d;
    bus.frame_ready = fr;
`ifdef FRAME_FLUSH_EN
    bus.flush       = fl;
`endif
    @(posedge clk);
    model_step(v, d, fr, fl);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_data     = 8'h00;
    bus.frame_ready = 1'b0;
`ifdef FRAME_FLUSH_EN
    bus.flush       = 1'b0;
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("rst_fill_count", 32'(bus.fill_count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_slot%0d", i + 1), 32'(slot_of(i)), 32'd0);
  endtask

  task automatic run_table(input string tag, input vec_t vec[$]);
    foreach (vec[k]) begin
      cycle(vec[k].vld, vec[k].dat, vec[k].frdy, vec[k].flsh);
      chk($sformatf("%s[%0d]_fill", tag, k), 32'(bus.fill_count), 32'(vec[k].e_fill));
      chk($sformatf("%s[%0d]_rdy", tag, k), 32'(bus.in_ready), 32'(vec[k].e_rdy));
      chk($sformatf("%s[%0d]_fv", tag, k), 32'(bus.frame_valid), 32'(vec[k].e_fv));
      chk($sformatf("%s[%0d]_cnt", tag, k), 32'(bus.frame_cnt), 32'(vec[k].e_cnt));
    end
  endtask

  task automatic fill_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, base + 8'(i), 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vec[$];
    logic [7:0] pi_b [8];
    logic [7:0] b;

    do_reset();

    // Back-to-back stream 10..80 with frame_ready held high.
    for (int k = 0; k < 8; k++)
      vec.push_back('{1'b1, 8'(16 * (k + 1)), 1'b1, 1'b0, 4'(k + 1), (k != 7), (k == 7), 16'd0});
    vec.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 16'd1});
    run_table("stream", vec);
    for (int i = 0; i < 8; i++) chk($sformatf("stream_slot%0d", i + 1), 32'(slot_of(i)), 32'(16 * (i + 1)));

    // Frame held for 5 cycles while 8'hAA is offered and refused.
    fill_bytes(8'h21, 8);
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, 8'hAA, 1'b0, 1'b0);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_frame_valid", 32'(bus.frame_valid), 32'd1);
      chk("hold_slot1", 32'(bus.input_1), 32'h21);
      chk("hold_slot8", 32'(bus.input_8), 32'h28);
    end
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("handoff_fill", 32'(bus.fill_count), 32'd0);
    chk("handoff_slot1_kept", 32'(bus.input_1), 32'h21);
    chk("handoff_cnt", 32'(bus.frame_cnt), 32'd2);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("next_fill", 32'(bus.fill_count), 32'd1);
    chk("next_slot1", 32'(bus.input_1), 32'hAA);
    fill_bytes(8'h41, 7);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // in_valid toggling: fill_count moves only on accepts.
    pi_b = '{8'h03, 8'h01, 8'h04, 8'h01, 8'h05, 8'h09, 8'h02, 8'h06};
    vec.delete();
    for (int i = 0; i < 8; i++) begin
      vec.push_back('{1'b1, pi_b[i], 1'b0, 1'b0, 4'(i + 1), (i != 7), (i == 7), 16'd3});
      vec.push_back('{1'b0, 8'hEE, 1'b0, 1'b0, 4'(i + 1), (i != 7), (i == 7), 16'd3});
    end
    run_table("toggle", vec);
    for (int i = 0; i < 8; i++) chk($sformatf("toggle_slot%0d", i + 1), 32'(slot_of(i)), 32'(pi_b[i]));
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset in the middle of a frame discards it.
    fill_bytes(8'h51, 5);
    do_reset();
    fill_bytes(8'h61, 8);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_cnt", 32'(bus.frame_cnt), 32'd1);
    for (int i = 0; i < 8; i++) chk($sformatf("post_rst_slot%0d", i + 1), 32'(slot_of(i)), 32'(8'h61 + 8'(i)));

`ifdef FRAME_FLUSH_EN
    cycle(1'b1, 8'h05, 1'b0, 1'b0);
    cycle(1'b1, 8'h07, 1'b0, 1'b0);
    cycle(1'b1, 8'h09, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("flush_fv", 32'(bus.frame_valid), 32'd1);
    chk("flush_fill", 32'(bus.fill_count), 32'd8);
    chk("flush_slot3", 32'(bus.input_3), 32'h09);
    chk("flush_slot4", 32'(bus.input_4), 32'hFF);
    chk("flush_slot8", 32'(bus.input_8), 32'hFF);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("flush_empty_fv", 32'(bus.frame_valid), 32'd0);
    chk("flush_empty_fill", 32'(bus.fill_count), 32'd0);
    cycle(1'b1, 8'h33, 1'b0, 1'b1);
    chk("flush_accept_slot1", 32'(bus.input_1), 32'h33);
    chk("flush_accept_slot2", 32'(bus.input_2), 32'hFF);
    chk("flush_accept_fv", 32'(bus.frame_valid), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      b = 8'($urandom);
      cycle(($urandom_range(0, 9) < 7), b, ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0));
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Counter wrap from 16'hFFFF.
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    m_cnt = 16'hFFFF;
    chk("wrap_preload", 32'(bus.frame_cnt), 32'hFFFF);
    if (bus.frame_valid) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    while (!bus.frame_valid) cycle(1'b1, 8'h71, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap_cnt", 32'(bus.frame_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
